// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared state encoding and width defaults for the fetch stage
package instr_fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/DFlipFlop.sv
// rtl/DFlipFlop.sv - width-parameterised enabled register, clears to zero on reset
module DFlipFlop #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_q <= '0;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_timeout.sv
// rtl/fetch_timeout.sv - saturating wait counter; expired flags the TIMEOUT-th idle wait cycle
module fetch_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != C_MAX))
      r_count <= r_count + 1'b1;
  end

  // Fires during the cycle whose edge would bring the count to TIMEOUT.
  assign o_expired = (TIMEOUT > 0) && i_enable && (r_count == C_LAST);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetches imem[pc] over req/ack and holds it in ir for decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc,
  output logic               loadpc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               flush,
  output logic               fetch_err
);

  fetch_state_t      r_state;
  logic              r_imem_req;
  logic              r_loadpc;
  logic              r_ir_valid;
  logic              r_fetch_err;
  logic [ADDR_W-1:0] r_imem_addr;

  logic w_busy;
  logic w_start;
  logic w_tmo_clear;
  logic w_expired;
  logic w_ir_load;

  assign w_busy    = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_ir_load = (r_state == ST_WAIT) && imem_ack && !flush;
  assign w_start   = ((r_state == ST_IDLE) && fetch_en && !flush) ||
                     ((r_state == ST_HOLD) && ir_ready && fetch_en && !flush);
  assign w_tmo_clear = w_start || ((r_state == ST_WAIT) && flush && !imem_ack);

  fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_busy && !imem_ack),
    .o_expired (w_expired)
  );

  DFlipFlop #(.WIDTH(INSTR_W)) u_ir (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_ir_load),
    .i_d     (imem_rdata),
    .o_q     (ir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_ir_valid  <= 1'b0;
      r_loadpc    <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_loadpc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_imem_addr <= pc;
            r_imem_req  <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            if (!flush) begin
              r_ir_valid <= 1'b1;
              r_loadpc   <= 1'b1;
              r_state    <= ST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
            r_imem_req  <= 1'b0;
            r_state     <= ST_ERR;
          end else if (flush) begin
            // The request stays up: memory still owes us an ack to discard.
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
            r_imem_req  <= 1'b0;
            r_state     <= ST_ERR;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            r_ir_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (ir_ready) begin
            r_ir_valid <= 1'b0;
            if (fetch_en) begin
              r_imem_addr <= pc;
              r_imem_req  <= 1'b1;
              r_state     <= ST_WAIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          r_imem_req <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign loadpc    = r_loadpc;
  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign ir_valid  = r_ir_valid;
  assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  pc;
  logic        loadpc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        flush;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  bit mon_on = 0;

  logic [15:0] mem [256];
  logic [7:0]  exp_addr_q [$];
  logic [15:0] exp_data_q [$];

  instr_fetch #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .pc         (pc),
    .loadpc     (loadpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .flush      (flush),
    .fetch_err  (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // The bench plays the program counter: it advances by one on every loadpc pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (loadpc) pc = pc + 8'd1;
  endtask

  // Scoreboard monitor: compares fetch addresses on ack and words on decode handshake.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) chk("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
        else chk("rand_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (ir_valid && ir_ready) begin
        if (exp_data_q.size() == 0) chk("unexpected_ir", 32'(ir), 32'hFFFF_FFFF);
        else chk("rand_ir", 32'(ir), 32'(exp_data_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] model_addr;
    int lat;
    int waited;
    int delivered;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    reset = 1'b1; fetch_en = 1'b0; pc = 8'h00; imem_ack = 1'b0;
    imem_rdata = 16'h0000; ir_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_loadpc", 32'(loadpc), 0);
    chk("rst_err", 32'(fetch_err), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    reset = 1'b0;

    // Reset while waiting on memory
    pc = 8'h10; fetch_en = 1'b1; tick();
    chk("midwait_req", 32'(imem_req), 1);
    chk("midwait_addr", 32'(imem_addr), 32'h10);
    fetch_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    chk("rstwait_req", 32'(imem_req), 0);
    chk("rstwait_ir_valid", 32'(ir_valid), 0);
    chk("rstwait_err", 32'(fetch_err), 0);
    tick();
    chk("rstwait_idle", 32'(imem_req), 0);

    // Zero-wait fetch
    pc = 8'h05; fetch_en = 1'b1; tick();
    chk("zw_addr", 32'(imem_addr), 32'h05);
    chk("zw_req", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = 16'hA5C3; fetch_en = 1'b0; tick(); imem_ack = 1'b0;
    chk("zw_ir", 32'(ir), 32'hA5C3);
    chk("zw_ir_valid", 32'(ir_valid), 1);
    chk("zw_loadpc", 32'(loadpc), 1);
    chk("zw_req_drop", 32'(imem_req), 0);
    tick();
    chk("zw_loadpc_once", 32'(loadpc), 0);

    // Back-pressure from decode
    fetch_en = 1'b1;
    repeat (4) begin
      tick();
      chk("bp_ir", 32'(ir), 32'hA5C3);
      chk("bp_valid", 32'(ir_valid), 1);
      chk("bp_no_req", 32'(imem_req), 0);
    end
    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
    chk("bp_next_valid", 32'(ir_valid), 0);
    chk("bp_next_req", 32'(imem_req), 1);
    chk("bp_next_addr", 32'(imem_addr), 32'h06);

    // Flush in WAIT, late ack is drained
    fetch_en = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    chk("drain_req0", 32'(imem_req), 1);
    repeat (2) begin
      tick();
      chk("drain_req", 32'(imem_req), 1);
      chk("drain_valid", 32'(ir_valid), 0);
      chk("drain_loadpc", 32'(loadpc), 0);
    end
    imem_ack = 1'b1; imem_rdata = 16'hFFFF; tick(); imem_ack = 1'b0;
    chk("drain_ack_req", 32'(imem_req), 0);
    chk("drain_ack_valid", 32'(ir_valid), 0);
    chk("drain_ack_loadpc", 32'(loadpc), 0);
    tick();
    chk("drain_idle_req", 32'(imem_req), 0);
    chk("drain_idle_loadpc", 32'(loadpc), 0);
    chk("drain_ir_kept", 32'(ir), 32'hA5C3);

    // Flush and ir_ready together in HOLD
    fetch_en = 1'b1; tick();
    chk("fh_addr", 32'(imem_addr), 32'h06);
    imem_ack = 1'b1; imem_rdata = 16'h1234; tick(); imem_ack = 1'b0;
    chk("fh_ir", 32'(ir), 32'h1234);
    flush = 1'b1; ir_ready = 1'b1; tick();
    flush = 1'b0; ir_ready = 1'b0; fetch_en = 1'b0;
    chk("fh_valid", 32'(ir_valid), 0);
    chk("fh_no_fetch", 32'(imem_req), 0);
    tick();
    chk("fh_idle", 32'(imem_req), 0);

    // Address wrap then timeout
    pc = 8'hFF; fetch_en = 1'b1; tick();
    chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
    imem_ack = 1'b1; imem_rdata = 16'h0BAD; tick(); imem_ack = 1'b0;
    chk("wrap_ir", 32'(ir), 32'h0BAD);
    ir_ready = 1'b1; tick(); ir_ready = 1'b0; fetch_en = 1'b0;
    chk("wrap_addr_00", 32'(imem_addr), 32'h00);
    chk("wrap_req", 32'(imem_req), 1);
    repeat (14) tick();
    chk("tmo_err_early", 32'(fetch_err), 0);
    chk("tmo_req_early", 32'(imem_req), 1);
    tick();
    chk("tmo_err", 32'(fetch_err), 1);
    chk("tmo_req", 32'(imem_req), 0);
    fetch_en = 1'b1; imem_ack = 1'b1;
    repeat (3) begin
      tick();
      chk("err_sticky", 32'(fetch_err), 1);
      chk("err_req", 32'(imem_req), 0);
      chk("err_valid", 32'(ir_valid), 0);
      chk("err_loadpc", 32'(loadpc), 0);
    end
    imem_ack = 1'b0; fetch_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    chk("err_cleared", 32'(fetch_err), 0);

    // Randomized traffic: k-th delivered word must be mem[pc0 + k]
    pc = 8'($urandom);
    model_addr = pc;
    lat = $urandom_range(0, 3);
    waited = 0;
    delivered = 0;
    mon_on = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (ir_valid && ir_ready) delivered++;
      fetch_en = (cyc < 1450) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ir_ready = (cyc < 1450) ? 1'($urandom) : 1'b1;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (waited >= lat) begin
          imem_ack = 1'b1;
          imem_rdata = mem[imem_addr];
          exp_addr_q.push_back(model_addr);
          exp_data_q.push_back(mem[model_addr]);
          model_addr = model_addr + 8'd1;
          waited = 0;
          lat = $urandom_range(0, 3);
        end else begin
          waited++;
        end
      end
    end
    tick();
    mon_on = 0;
    imem_ack = 1'b0;
    chk("rand_addr_q_empty", 32'(exp_addr_q.size()), 0);
    chk("rand_data_q_empty", 32'(exp_data_q.size()), 0);
    chk("rand_progress", 32'(delivered > 50), 1);
    chk("rand_no_err", 32'(fetch_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
